hamming_pair_encoder: RTL and testbench
=======================================

# hamming_pair_encoder

Downstream consumer of the nibble-serialiser FSM in the Hamming peripheral. Each cycle it takes one 4-bit nibble plus the serialiser's first-nibble flag and encodes the nibble as Hamming(7,4). It pairs the low and high codewords of a byte into one result word and presents that word to the CPU-side result register through a valid/ready handshake. Pairing errors and dropped pairs are reported through sticky flags.

## Interface
Parameters: none.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- nib_i  in  4  nibble from the serialiser
- first_i  in  1  high when nib_i is the low nibble (in[3:0]); low when it is the high nibble (in[7:4])
- nib_valid_i  in  1  nib_i/first_i qualify this cycle; tie high when the serialiser free-runs
- code_ready_i  in  1  consumer accepts code_o this cycle
- clr_i  in  1  synchronous clear of the sticky flags
- code_o  out  16  packed codeword pair
- code_valid_o  out  1  code_o holds an unconsumed pair
- seq_err_o  out  1  sticky: out-of-sequence nibble seen
- overrun_o  out  1  sticky: a completed pair was dropped because the output slot was full

## Operation
- Codeword for d[3:0]:
  - cw[0] = d0^d1^d3
  - cw[1] = d0^d2^d3
  - cw[2] = d0
  - cw[3] = d1^d2^d3
  - cw[4] = d1
  - cw[5] = d2
  - cw[6] = d3
- The FSM has two states, WAIT_LOW (reset state) and WAIT_HIGH. A nibble is accepted when nib_valid_i=1.
- WAIT_LOW, first_i=1: the low codeword is stored in an internal register and the FSM moves to WAIT_HIGH.
- WAIT_LOW, first_i=0: the nibble is discarded, seq_err_o is set, and the FSM stays in WAIT_LOW.
- WAIT_HIGH, first_i=0: the pair is complete and the FSM returns to WAIT_LOW.
  - If the slot is free, the pair loads into code_o. The slot is free when code_valid_o=0, or when code_valid_o=1 and code_ready_i=1 in the same cycle.
  - If the slot is not free, the pair is dropped, overrun_o is set, and code_o is left unchanged.
- WAIT_HIGH, first_i=1: seq_err_o is set. The new nibble replaces the stored low codeword and the FSM stays in WAIT_HIGH.
- nib_valid_i=0: the state and the stored low codeword hold.
- Packing without SECDED: code_o[6:0] = low cw, code_o[13:7] = high cw, code_o[15:14] = 0.
- code_o is held stable while code_valid_o=1 and code_ready_i=0.
- clr_i=1 clears seq_err_o and overrun_o. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - code_o = 0
  - code_valid_o = 0
  - seq_err_o = 0
  - overrun_o = 0
  - FSM in WAIT_LOW, stored low codeword = 0
- Reset mid-pair discards the stored low codeword. The first accepted nibble after reset must carry first_i=1.
- Latency: a high nibble accepted on edge N gives code_valid_o=1 and valid code_o after edge N.
- code_valid_o falls after the edge on which code_ready_i=1, unless a new pair loads on that same edge.
- Throughput: one pair per 2 cycles, matching the free-running serialiser. Overrun is impossible while code_ready_i is held at 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- HAMMING_SECDED_EN defined:
  - Each codeword gets cw[7] = XOR of cw[6:0] (overall parity, SECDED).
  - Packing: code_o[7:0] = low cw, code_o[15:8] = high cw.
- HAMMING_SECDED_EN undefined: plain 7-bit codewords, packed as described under Operation.

## Test plan
- Free-running serialiser with in=0x000000AB, nib_valid_i=1, code_ready_i=1 -> code_o=0x2955 (0xD255 with SECDED), code_valid_o=1 one cycle after the high nibble, seq_err_o=0.
- Nibble pairs 0x0/0x0, then 0xF/0xF -> code_o=0x0000, then 0x3FFF (0xFFFF with SECDED).
- code_ready_i=0 across two complete pairs (bytes 0xAB then 0x55) -> code_o stays 0x2955 and overrun_o=1. Raising code_ready_i drains 0x2955 and code_valid_o falls.
- Sequencing errors:
  - Start with first_i=0 -> seq_err_o=1 and no output.
  - first_i=1 twice, low nibbles 0x3 then 0xB, followed by high 0xA -> code_o=0x2955.
  - Then clr_i=1 -> seq_err_o=0.
- Assert rst in WAIT_HIGH after low nibble 0xB:
  - All outputs go to 0 immediately.
  - Next pair 0x5/0xA -> code_o = (0x52<<7)|0x2D = 0x292D.
- Hold nib_valid_i=0 for 3 cycles between the low and high nibbles -> state holds and the pair output is identical to the uninterrupted case.

Source files
------------

// File: rtl/hamming_pair_encoder.sv
// hamming_pair_encoder
// Encodes each incoming nibble as a Hamming(7,4) codeword and pairs the
// low and high codewords of a byte into one result word. The result word
// is offered through a one-entry valid/ready output slot. Sticky flags
// report out-of-sequence nibbles and pairs dropped because the slot was full.
//
// Build option: define HAMMING_SECDED_EN to append an overall parity bit
// (cw[7]) to each codeword and pack the two 8-bit codewords into code_o.
// Without it, the two 7-bit codewords sit in code_o[13:0] and the top two
// bits of code_o are zero.
module hamming_pair_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  nib_i,
  input  logic        first_i,
  input  logic        nib_valid_i,
  input  logic        code_ready_i,
  input  logic        clr_i,
  output logic [15:0] code_o,
  output logic        code_valid_o,
  output logic        seq_err_o,
  output logic        overrun_o
);

`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  typedef enum logic {
    WAIT_LOW  = 1'b0,
    WAIT_HIGH = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   low_cw_reg, low_cw_next;
  logic [15:0]     code_reg, code_next;
  logic            valid_reg, valid_next;
  logic            seq_err_reg, seq_err_next;
  logic            overrun_reg, overrun_next;

  logic [CW-1:0]   cw_in;
  logic [15:0]     pair_word;
  logic            slot_free;
  logic            seq_set;
  logic            overrun_set;

  // Hamming(7,4) encoding of a single nibble, optionally extended with
  // an overall parity bit for single-error-correct / double-error-detect.
  function automatic logic [CW-1:0] encode(input logic [3:0] d);
    logic [6:0]    h;
    logic [CW-1:0] r;
    h[0] = d[0] ^ d[1] ^ d[3];
    h[1] = d[0] ^ d[2] ^ d[3];
    h[2] = d[0];
    h[3] = d[1] ^ d[2] ^ d[3];
    h[4] = d[1];
    h[5] = d[2];
    h[6] = d[3];
`ifdef HAMMING_SECDED_EN
    r = {^h, h};
`else
    r = h;
`endif
    return r;
  endfunction

  // Codeword of the nibble currently presented, and the word it would
  // complete together with the stored low codeword.
  always_comb begin
    cw_in = encode(nib_i);
`ifdef HAMMING_SECDED_EN
    pair_word = {cw_in, low_cw_reg};
`else
    pair_word = {2'b00, cw_in, low_cw_reg};
`endif
  end

  // The output slot can take a new pair if it is empty or being drained
  // on this same edge.
  assign slot_free = !valid_reg || code_ready_i;

  // Next-state logic: pairing FSM, output slot and sticky flags.
  always_comb begin
    state_next   = state_reg;
    low_cw_next  = low_cw_reg;
    code_next    = code_reg;
    valid_next   = valid_reg && !code_ready_i;
    seq_set      = 1'b0;
    overrun_set  = 1'b0;

    if (nib_valid_i) begin
      case (state_reg)
        WAIT_LOW: begin
          if (first_i) begin
            low_cw_next = cw_in;
            state_next  = WAIT_HIGH;
          end else begin
            // A high nibble with no low partner is thrown away.
            seq_set = 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!first_i) begin
            state_next = WAIT_LOW;
            if (slot_free) begin
              code_next  = pair_word;
              valid_next = 1'b1;
            end else begin
              // Slot still owned by the consumer: keep its word intact.
              overrun_set = 1'b1;
            end
          end else begin
            // A second low nibble restarts the pair with the newer data.
            seq_set     = 1'b1;
            low_cw_next = cw_in;
          end
        end
        default: state_next = WAIT_LOW;
      endcase
    end

    // Clear is overridden by a simultaneous set event.
    seq_err_next = seq_set     || (seq_err_reg && !clr_i);
    overrun_next = overrun_set || (overrun_reg && !clr_i);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= WAIT_LOW;
      low_cw_reg  <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      seq_err_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      low_cw_reg  <= low_cw_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      seq_err_reg <= seq_err_next;
      overrun_reg <= overrun_next;
    end
  end

  assign code_o       = code_reg;
  assign code_valid_o = valid_reg;
  assign seq_err_o    = seq_err_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_hamming_pair_encoder.sv
// tb_hamming_pair_encoder
// Directed checks of nibble pairing, handshake, sticky flags and reset.
// Expected words are hand-computed constants for both codeword widths.
module tb_hamming_pair_encoder;

  logic        clk;
  logic        rst;
  logic [3:0]  nib_i;
  logic        first_i;
  logic        nib_valid_i;
  logic        code_ready_i;
  logic        clr_i;
  logic [15:0] code_o;
  logic        code_valid_o;
  logic        seq_err_o;
  logic        overrun_o;

  int total;
  int bad;

`ifdef HAMMING_SECDED_EN
  localparam logic [15:0] EXP_AB = 16'hD255;
  localparam logic [15:0] EXP_00 = 16'h0000;
  localparam logic [15:0] EXP_FF = 16'hFFFF;
  localparam logic [15:0] EXP_5A = 16'hD22D;
`else
  localparam logic [15:0] EXP_AB = 16'h2955;
  localparam logic [15:0] EXP_00 = 16'h0000;
  localparam logic [15:0] EXP_FF = 16'h3FFF;
  localparam logic [15:0] EXP_5A = 16'h292D;
`endif

  hamming_pair_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .nib_i        (nib_i),
    .first_i      (first_i),
    .nib_valid_i  (nib_valid_i),
    .code_ready_i (code_ready_i),
    .clr_i        (clr_i),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .seq_err_o    (seq_err_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  // Present one nibble for one clock edge, then settle 1 time unit past it.
  task automatic nib(input logic [3:0] n, input logic first, input logic valid);
    nib_i       = n;
    first_i     = first;
    nib_valid_i = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nib(4'h3, 1'b1, 1'b0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    nib_i        = 4'h0;
    first_i      = 1'b0;
    nib_valid_i  = 1'b0;
    code_ready_i = 1'b1;
    clr_i        = 1'b0;

    // Reset state
    #3;
    check("rst_code",    code_o, 16'h0000);
    check("rst_valid",   {15'd0, code_valid_o}, 16'd0);
    check("rst_seq",     {15'd0, seq_err_o}, 16'd0);
    check("rst_overrun", {15'd0, overrun_o}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running byte 0xAB with the consumer always ready
    nib(4'hB, 1'b1, 1'b1);
    check("ab_low_valid", {15'd0, code_valid_o}, 16'd0);
    nib(4'hA, 1'b0, 1'b1);
    check("ab_code",  code_o, EXP_AB);
    check("ab_valid", {15'd0, code_valid_o}, 16'd1);
    check("ab_seq",   {15'd0, seq_err_o}, 16'd0);
    nib(4'h0, 1'b1, 1'b1);
    check("ab_drained", {15'd0, code_valid_o}, 16'd0);

    // All-zero and all-one nibbles
    nib(4'h0, 1'b0, 1'b1);
    check("00_code", code_o, EXP_00);
    check("00_valid", {15'd0, code_valid_o}, 16'd1);
    nib(4'hF, 1'b1, 1'b1);
    nib(4'hF, 1'b0, 1'b1);
    check("ff_code", code_o, EXP_FF);

    // Consumer stalls across two pairs: second pair is dropped
    nib(4'hB, 1'b1, 1'b1);
    code_ready_i = 1'b0;
    nib(4'hA, 1'b0, 1'b1);
    check("stall_ab_code", code_o, EXP_AB);
    nib(4'h5, 1'b1, 1'b1);
    nib(4'h5, 1'b0, 1'b1);
    check("stall_hold_code", code_o, EXP_AB);
    check("stall_valid",     {15'd0, code_valid_o}, 16'd1);
    check("stall_overrun",   {15'd0, overrun_o}, 16'd1);
    code_ready_i = 1'b1;
    idle();
    check("drain_valid",    {15'd0, code_valid_o}, 16'd0);
    check("overrun_sticky", {15'd0, overrun_o}, 16'd1);
    clr_i = 1'b1;
    idle();
    clr_i = 1'b0;
    check("overrun_clr", {15'd0, overrun_o}, 16'd0);

    // Sequencing errors
    nib(4'h5, 1'b0, 1'b1);
    check("orphan_seq",   {15'd0, seq_err_o}, 16'd1);
    check("orphan_valid", {15'd0, code_valid_o}, 16'd0);
    nib(4'h3, 1'b1, 1'b1);
    nib(4'hB, 1'b1, 1'b1);
    nib(4'hA, 1'b0, 1'b1);
    check("relow_code",  code_o, EXP_AB);
    check("relow_valid", {15'd0, code_valid_o}, 16'd1);
    clr_i = 1'b1;
    idle();
    check("seq_clr", {15'd0, seq_err_o}, 16'd0);
    // Set wins over a simultaneous clear
    nib(4'h5, 1'b0, 1'b1);
    clr_i = 1'b0;
    check("seq_set_wins", {15'd0, seq_err_o}, 16'd1);

    // Asynchronous reset while waiting for the high nibble
    nib(4'hB, 1'b1, 1'b1);
    nib(4'hA, 1'b0, 1'b1);
    code_ready_i = 1'b0;
    nib(4'hB, 1'b1, 1'b1);
    check("pre_rst_valid", {15'd0, code_valid_o}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_code",  code_o, 16'h0000);
    check("async_rst_valid", {15'd0, code_valid_o}, 16'd0);
    check("async_rst_seq",   {15'd0, seq_err_o}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    code_ready_i = 1'b1;
    nib(4'h5, 1'b1, 1'b1);
    check("post_rst_seq", {15'd0, seq_err_o}, 16'd0);
    nib(4'hA, 1'b0, 1'b1);
    check("post_rst_code", code_o, EXP_5A);

    // Gap of three invalid cycles between low and high nibbles
    nib(4'hB, 1'b1, 1'b1);
    nib(4'h0, 1'b0, 1'b0);
    nib(4'h7, 1'b1, 1'b0);
    nib(4'hF, 1'b0, 1'b0);
    check("gap_valid", {15'd0, code_valid_o}, 16'd0);
    check("gap_seq",   {15'd0, seq_err_o}, 16'd0);
    nib(4'hA, 1'b0, 1'b1);
    check("gap_code",  code_o, EXP_AB);
    check("gap_valid_out", {15'd0, code_valid_o}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
